// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared helpers for the conv/ReLU/pool layer sequencer:
//            ceiling-log2 for sizing, FSM state encodings, and signed
//            saturation used when narrowing the MAC accumulator.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cnn_pkg;

   // Ceiling log2 for sizing index/counter widths at elaboration time.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Sequencer states (3-bit encoding).
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CONV = 3'd2;
   localparam logic [2:0] S_POOL = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // Clamp a sign-extended value into the signed range of 'width' bits.
   // The caller truncates the result to 'width' bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                   input int                 width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi)      return hi;
      else if (value < lo) return lo;
      else                 return value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/window_mac.sv
`default_nettype none
// ============================================================================
// Module   : window_mac
// Purpose  : Signed multiply-accumulate, one product per enabled cycle, with
//            a saturated (narrowed) view of the running accumulator.
// Ports    : clk      in   clock, rising edge
//            rst      in   asynchronous active-low reset
//            clr      in   synchronous abort clear
//            acc_clr  in   synchronous accumulator clear (next window)
//            en       in   accumulate pix*tap this cycle
//            pix/tap  in   signed operands, In_d_W bits
//            acc_sat  out  accumulator saturated to Out_d_W bits
// Revision : 1.0  initial release
// ============================================================================
module window_mac
   import cnn_pkg::*;
#(
   parameter int In_d_W  = 8,
   parameter int Acc_W   = 21,
   parameter int Out_d_W = 18
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      acc_clr,
   input  logic                      en,
   input  logic signed [In_d_W-1:0]  pix,
   input  logic signed [In_d_W-1:0]  tap,
   output logic signed [Out_d_W-1:0] acc_sat
);

   logic signed [2*In_d_W-1:0] w_prod;
   logic signed [Acc_W-1:0]    r_acc;

   assign w_prod = pix * tap;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_acc <= '0;
      else if (clr || acc_clr) r_acc <= '0;
      else if (en)             r_acc <= r_acc + {{(Acc_W-2*In_d_W){w_prod[2*In_d_W-1]}}, w_prod};
   end

   assign acc_sat = Out_d_W'(saturate({{(64-Acc_W){r_acc[Acc_W-1]}}, r_acc}, Out_d_W));

endmodule
`default_nettype wire

// File: rtl/cnn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_seq
// Purpose  : Multi-filter conv -> ReLU -> max-pool layer with its own
//            sequencer. Serial datapath: one MAC per cycle during CONV, one
//            pool compare per cycle during POOL.
// Ports    : clk      in   clock, rising edge
//            rst      in   asynchronous active-low reset
//            clr      in   synchronous abort/clear (wins over start)
//            start    in   run request, sampled in IDLE only
//            relu_en  in   1: ReLU after saturation, 0: identity
//            N        in   input map, pixel(r,c) at [(r*C_N+c)*In_d_W +:]
//            F        in   filters, tap(f,i,j) at [((f*R_F+i)*C_F+j)*In_d_W +:]
//            busy     out  high from LOAD through DONE
//            done     out  one-cycle pulse, Y valid
//            Y        out  out(f,r,c) at [((f*R_Po+r)*C_Po+c)*Out_d_W +:]
// Revision : 1.0  initial release
// ============================================================================
module cnn_layer_seq
   import cnn_pkg::*;
#(
   parameter  int In_d_W  = 8,
   parameter  int R_N     = 5,
   parameter  int C_N     = 5,
   parameter  int R_F     = 3,
   parameter  int C_F     = 3,
   parameter  int S_Conv  = 1,
   parameter  int N_Filt  = 2,
   parameter  int R_PA    = 2,
   parameter  int C_PA    = 2,
   parameter  int S_Pool  = 1,
   localparam int R_Co    = (R_N - R_F) / S_Conv + 1,
   localparam int C_Co    = (C_N - C_F) / S_Conv + 1,
   localparam int R_Po    = (R_Co - R_PA) / S_Pool + 1,
   localparam int C_Po    = (C_Co - C_PA) / S_Pool + 1,
   localparam int Out_d_W = 2 * In_d_W + 2,
   localparam int Acc_W   = 2 * In_d_W + clog2(R_F * C_F) + 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clr,
   input  logic                                start,
   input  logic                                relu_en,
   input  logic [R_N*C_N*In_d_W-1:0]           N,
   input  logic [N_Filt*R_F*C_F*In_d_W-1:0]    F,
   output logic                                busy,
   output logic                                done,
   output logic [N_Filt*R_Po*C_Po*Out_d_W-1:0] Y
);

   localparam int N_PIX  = R_N * C_N;
   localparam int N_TAP  = N_Filt * R_F * C_F;
   localparam int N_CB   = N_Filt * R_Co * C_Co;
   localparam int N_Y    = N_Filt * R_Po * C_Po;
   localparam int PIX_AW = (N_PIX > 1) ? clog2(N_PIX) : 1;
   localparam int TAP_AW = (N_TAP > 1) ? clog2(N_TAP) : 1;
   localparam int CB_AW  = (N_CB  > 1) ? clog2(N_CB)  : 1;
   localparam int Y_AW   = (N_Y   > 1) ? clog2(N_Y)   : 1;
   // Every loop limit is at most max(R_N, C_N, N_Filt).
   localparam int CW     = clog2(R_N + C_N + N_Filt + 1) + 1;

   logic [2:0] r_state;
   logic       r_relu;

   // Shared loop counters: f / output row / output col / window row / window col.
   // r_wb marks the write-back cycle that follows the last window element.
   logic [CW-1:0] r_f, r_row, r_col, r_i, r_j;
   logic          r_wb;

   logic signed [In_d_W-1:0]  r_pix  [N_PIX];
   logic signed [In_d_W-1:0]  r_tap  [N_TAP];
   logic signed [Out_d_W-1:0] r_cbuf [N_CB];
   logic signed [Out_d_W-1:0] r_y    [N_Y];
   logic signed [Out_d_W-1:0] r_max;

   logic [CW-1:0]             w_i_max, w_j_max, w_row_max, w_col_max;
   logic                      w_last_j, w_last_i, w_last_col, w_last_row, w_last_f;
   logic [PIX_AW-1:0]         w_pix_idx;
   logic [TAP_AW-1:0]         w_tap_idx;
   logic [CB_AW-1:0]          w_cb_wr_idx, w_cb_rd_idx;
   logic [Y_AW-1:0]           w_y_idx;
   logic signed [Out_d_W-1:0] w_mac_sat, w_relu_val, w_pool_elem;
   logic                      w_mac_en, w_acc_clr;

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

   // Loop limits depend on which phase the shared counters are walking.
   always_comb begin
      w_i_max   = CW'(R_F - 1);
      w_j_max   = CW'(C_F - 1);
      w_row_max = CW'(R_Co - 1);
      w_col_max = CW'(C_Co - 1);
      if (r_state == S_POOL) begin
         w_i_max   = CW'(R_PA - 1);
         w_j_max   = CW'(C_PA - 1);
         w_row_max = CW'(R_Po - 1);
         w_col_max = CW'(C_Po - 1);
      end
   end

   assign w_last_j   = (r_j   == w_j_max);
   assign w_last_i   = (r_i   == w_i_max);
   assign w_last_col = (r_col == w_col_max);
   assign w_last_row = (r_row == w_row_max);
   assign w_last_f   = (r_f   == CW'(N_Filt - 1));

   assign w_pix_idx   = PIX_AW'((int'(r_row) * S_Conv + int'(r_i)) * C_N + int'(r_col) * S_Conv + int'(r_j));
   assign w_tap_idx   = TAP_AW'((int'(r_f) * R_F + int'(r_i)) * C_F + int'(r_j));
   assign w_cb_wr_idx = CB_AW'((int'(r_f) * R_Co + int'(r_row)) * C_Co + int'(r_col));
   assign w_cb_rd_idx = CB_AW'((int'(r_f) * R_Co + int'(r_row) * S_Pool + int'(r_i)) * C_Co
                               + int'(r_col) * S_Pool + int'(r_j));
   assign w_y_idx     = Y_AW'((int'(r_f) * R_Po + int'(r_row)) * C_Po + int'(r_col));

   assign w_mac_en  = (r_state == S_CONV) && !r_wb;
   assign w_acc_clr = (r_state == S_CONV) &&  r_wb;

   window_mac #(
      .In_d_W  (In_d_W),
      .Acc_W   (Acc_W),
      .Out_d_W (Out_d_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .acc_clr (w_acc_clr),
      .en      (w_mac_en),
      .pix     (r_pix[w_pix_idx]),
      .tap     (r_tap[w_tap_idx]),
      .acc_sat (w_mac_sat)
   );

   assign w_relu_val  = (r_relu && w_mac_sat[Out_d_W-1]) ? '0 : w_mac_sat;
   assign w_pool_elem = r_cbuf[w_cb_rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_relu  <= 1'b0;
         r_f     <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_wb    <= 1'b0;
         r_max   <= '0;
         for (int k = 0; k < N_PIX; k++) r_pix[k]  <= '0;
         for (int k = 0; k < N_TAP; k++) r_tap[k]  <= '0;
         for (int k = 0; k < N_CB;  k++) r_cbuf[k] <= '0;
         for (int k = 0; k < N_Y;   k++) r_y[k]    <= '0;
      end else if (clr) begin
         r_state <= S_IDLE;
         r_relu  <= 1'b0;
         r_f     <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_wb    <= 1'b0;
         r_max   <= '0;
         for (int k = 0; k < N_PIX; k++) r_pix[k]  <= '0;
         for (int k = 0; k < N_TAP; k++) r_tap[k]  <= '0;
         for (int k = 0; k < N_CB;  k++) r_cbuf[k] <= '0;
         for (int k = 0; k < N_Y;   k++) r_y[k]    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_relu <= relu_en;
               for (int k = 0; k < N_PIX; k++) r_pix[k] <= N[k*In_d_W +: In_d_W];
               for (int k = 0; k < N_TAP; k++) r_tap[k] <= F[k*In_d_W +: In_d_W];
               r_state <= S_CONV;
            end
            S_CONV, S_POOL: begin
               if (r_state == S_CONV) begin
                  if (r_wb) r_cbuf[w_cb_wr_idx] <= w_relu_val;
               end else begin
                  if (r_wb)
                     r_y[w_y_idx] <= r_max;
                  else if ((r_i == '0 && r_j == '0) || (w_pool_elem > r_max))
                     r_max <= w_pool_elem;   // first element seeds the max
               end

               if (!r_wb) begin
                  if (w_last_j) begin
                     r_j <= '0;
                     if (w_last_i) begin
                        r_i  <= '0;
                        r_wb <= 1'b1;
                     end else begin
                        r_i <= r_i + 1'b1;
                     end
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end else begin
                  r_wb <= 1'b0;
                  if (w_last_col) begin
                     r_col <= '0;
                     if (w_last_row) begin
                        r_row <= '0;
                        if (w_last_f) begin
                           r_f     <= '0;
                           r_state <= (r_state == S_CONV) ? S_POOL : S_DONE;
                        end else begin
                           r_f <= r_f + 1'b1;
                        end
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_Y; g++) begin : g_y_flat
      assign Y[g*Out_d_W +: Out_d_W] = r_y[g];
   end

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_layer_seq
// Purpose  : Directed self-checking bench for cnn_layer_seq (default sizes):
//            table of {relu_en, N, F, expected Y} vectors plus hand-written
//            sequences for restart-while-busy, clr abort and async reset.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cnn_layer_seq;

   localparam int NW  = 5 * 5 * 8;
   localparam int FW  = 2 * 3 * 3 * 8;
   localparam int OW  = 18;
   localparam int NY  = 2 * 2 * 2;
   localparam int YW  = NY * OW;
   localparam int LAT = 221;

   logic          clk = 1'b0;
   logic          rst, clr, start, relu_en;
   logic [NW-1:0] N;
   logic [FW-1:0] F;
   logic          busy, done;
   logic [YW-1:0] Y;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cnn_layer_seq dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .start   (start),
      .relu_en (relu_en),
      .N       (N),
      .F       (F),
      .busy    (busy),
      .done    (done),
      .Y       (Y)
   );

   typedef struct {
      logic          relu;
      logic [NW-1:0] n;
      logic [FW-1:0] f;
      logic [YW-1:0] exp_y;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string what, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", what, act, exp);
      end
   endtask

   function automatic logic [NW-1:0] ramp_n();
      logic [NW-1:0] r;
      r = '0;
      for (int rr = 0; rr < 5; rr++)
         for (int cc = 0; cc < 5; cc++)
            r[(rr*5+cc)*8 +: 8] = 8'(5*rr + cc);
      return r;
   endfunction

   function automatic logic [NW-1:0] const_n(input int v);
      logic [NW-1:0] r;
      for (int k = 0; k < 25; k++) r[k*8 +: 8] = 8'(v);
      return r;
   endfunction

   // Filter 0 all v0; filter 1 all v1, or only the centre tap when f1_centre.
   function automatic logic [FW-1:0] mk_f(input int v0, input int v1, input bit f1_centre);
      logic [FW-1:0] r;
      for (int t = 0; t < 9; t++) begin
         r[t*8 +: 8]     = 8'(v0);
         r[(9+t)*8 +: 8] = (f1_centre && t != 4) ? 8'd0 : 8'(v1);
      end
      return r;
   endfunction

   // Slice order: f0 (0,0),(0,1),(1,0),(1,1), then f1 likewise.
   function automatic logic [YW-1:0] mk_y(input int a0, input int a1, input int a2, input int a3,
                                          input int b0, input int b1, input int b2, input int b3);
      return {18'(b3), 18'(b2), 18'(b1), 18'(b0), 18'(a3), 18'(a2), 18'(a1), 18'(a0)};
   endfunction

   task automatic check_y(input string tag, input logic [YW-1:0] e);
      for (int k = 0; k < NY; k++)
         chk($sformatf("%s y[%0d]", tag, k), int'($signed(Y[k*OW +: OW])), int'($signed(e[k*OW +: OW])));
   endtask

   // Launch a run and watch up to 300 cycles. At cycle pa the inputs are
   // scrambled and start re-pulsed; at cycle pb start is pulsed again.
   task automatic run_dut(input logic rel, input logic [NW-1:0] n, input logic [FW-1:0] f,
                          input int pa, input int pb,
                          output int lat, output int ndone, output int busy_ok);
      @(negedge clk);
      N = n; F = f; relu_en = rel; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1; ndone = 0; busy_ok = 1;
      for (int c = 0; c < 300; c++) begin
         if (done) begin
            ndone++;
            if (lat < 0) lat = c;
         end
         if (lat < 0 && !busy) busy_ok = 0;
         start = (c == pa || c == pb);
         if (c == pa) begin
            N = '1; F = '1; relu_en = ~relu_en;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input string tag, input int pa, input int pb);
      int lat, nd, bok;
      run_dut(vecs[idx].relu, vecs[idx].n, vecs[idx].f, pa, pb, lat, nd, bok);
      chk({tag, " latency"}, lat, LAT);
      chk({tag, " done_count"}, nd, 1);
      chk({tag, " busy_held"}, bok, 1);
      check_y(tag, vecs[idx].exp_y);
   endtask

   initial begin
      int nd;
      rst = 1'b0; clr = 1'b0; start = 1'b0; relu_en = 1'b0; N = '0; F = '0;

      vecs[0] = '{1'b1, ramp_n(), mk_f(1, 1, 1),
                  mk_y(108, 117, 153, 162, 12, 13, 17, 18)};
      vecs[1] = '{1'b1, ramp_n(), mk_f(1, -1, 0),
                  mk_y(108, 117, 153, 162, 0, 0, 0, 0)};
      vecs[2] = '{1'b0, ramp_n(), mk_f(1, -1, 0),
                  mk_y(108, 117, 153, 162, -54, -63, -99, -108)};
      vecs[3] = '{1'b0, const_n(-128), mk_f(-128, 127, 0),
                  mk_y(131071, 131071, 131071, 131071, -131072, -131072, -131072, -131072)};

      repeat (2) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset y_nonzero", int'(Y != '0), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 4; v++)
         run_vec(v, $sformatf("vec%0d", v), -1, -1);

      // start pulses while busy are ignored; inputs changed mid-run are ignored
      run_vec(0, "restart_busy", 5, 50);
      chk("restart_busy idle_after", int'(busy), 0);

      // clr at cycle 100 of a run
      @(negedge clk);
      N = vecs[0].n; F = vecs[0].f; relu_en = vecs[0].relu; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr busy", int'(busy), 0);
      chk("clr done", int'(done), 0);
      chk("clr y_nonzero", int'(Y != '0), 0);
      nd = 0;
      for (int c = 0; c < 250; c++) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("clr done_count", nd, 0);
      run_vec(0, "after_clr", -1, -1);

      // asynchronous reset between edges, mid-CONV
      @(negedge clk);
      N = vecs[0].n; F = vecs[0].f; relu_en = vecs[0].relu; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst busy", int'(busy), 0);
      chk("async_rst done", int'(done), 0);
      chk("async_rst y_nonzero", int'(Y != '0), 0);
      @(negedge clk);
      rst = 1'b1;
      run_vec(0, "after_rst", -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
